// File: rtl/tlp_rx_parser.sv
`default_nettype none
// ============================================================================
// Module   : tlp_rx_parser
// Brief    : Parses register-BAR RX TLPs into RegRead / RegWrite / ErrorCode
//            actions buffered in a FWFT FIFO. Define TLP_RX_4DW_EN to accept
//            4DW headers.
// Revision : 1.0 - initial release
// ============================================================================
module tlp_rx_parser #(
    parameter int REGADDR_NBITS = 10,
    parameter int MAX_BURST_DW  = 16,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                      pcieClk_in,
    input  logic                      reset_in,
    input  logic [63:0]               rxData_in,
    input  logic                      rxValid_in,
    output logic                      rxReady_out,
    input  logic                      rxSOP_in,
    input  logic                      rxEOP_in,
    input  logic [1:0]                rxBar_in,
    output logic [33+REGADDR_NBITS:0] actData_out,
    output logic                      actValid_out,
    input  logic                      actReady_in,
    output logic [15:0]               errCount_out
);

    localparam int c_ACT_NBITS = 34 + REGADDR_NBITS;
    localparam int c_PTR_NBITS = $clog2(FIFO_DEPTH);
    localparam int c_CNT_NBITS = c_PTR_NBITS + 1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_HDR1 = 2'd1;
    localparam logic [1:0] c_ST_DATA = 2'd2;
    localparam logic [1:0] c_ST_DROP = 2'd3;

    localparam logic [1:0] c_SOP_REG   = 2'd1;
    localparam logic [1:0] c_TYP_READ  = 2'd1;
    localparam logic [1:0] c_TYP_WRITE = 2'd2;
    localparam logic [1:0] c_TYP_ERROR = 2'd3;
    localparam logic [4:0] c_TYPE_MEM_RW = 5'd0;

    localparam logic [31:0] c_ERR_LEN   = 32'd1;
    localparam logic [31:0] c_ERR_RDLEN = 32'd2;
    localparam logic [31:0] c_ERR_TYPE  = 32'd3;
    localparam logic [31:0] c_ERR_EOP   = 32'd4;
    localparam logic [31:0] c_ERR_ABORT = 32'd5;

    localparam logic [9:0]               c_MAX_LEN  = 10'(MAX_BURST_DW);
    localparam logic [9:0]               c_LEN_ONE  = 10'd1;
    localparam logic [REGADDR_NBITS-1:0] c_CHAN_ONE = REGADDR_NBITS'(1);
    localparam logic [c_PTR_NBITS-1:0]   c_PTR_ONE  = c_PTR_NBITS'(1);
    localparam logic [c_CNT_NBITS-1:0]   c_CNT_FULL = c_CNT_NBITS'(FIFO_DEPTH);
    localparam logic [c_CNT_NBITS-1:0]   c_CNT_RDY  = c_CNT_NBITS'(FIFO_DEPTH - 2);

    function automatic logic [c_ACT_NBITS-1:0] mk_act(input logic [1:0] typ,
                                                      input logic [REGADDR_NBITS-1:0] chan,
                                                      input logic [31:0] payload);
        return {typ, chan, payload};
    endfunction

    function automatic logic [c_ACT_NBITS-1:0] mk_err(input logic [31:0] code);
        return {c_TYP_ERROR, {REGADDR_NBITS{1'b0}}, code};
    endfunction

    logic [1:0]               r_state, w_state_nxt, w_cur_state;
    logic [2:0]               r_fmt, w_fmt_nxt;
    logic [4:0]               r_type, w_type_nxt;
    logic [9:0]               r_len, w_len_nxt;
    logic [15:0]              r_req_id, w_req_id_nxt;
    logic [7:0]               r_tag, w_tag_nxt;
    logic                     r_is_reg, w_is_reg_nxt;
    logic [REGADDR_NBITS-1:0] r_chan, w_chan_nxt, w_ch;
    logic [9:0]               r_rem, w_rem_nxt, w_rm;
    logic                     r_skip_lo, w_skip_lo_nxt;
    logic                     r_err_pend, w_err_pend_nxt;
    logic [15:0]              r_err_cnt;
    logic [16:0]              w_err_sum;
    logic [1:0]               w_err_add;

    logic [c_ACT_NBITS-1:0]      r_mem [FIFO_DEPTH];
    logic [c_PTR_NBITS-1:0]      r_wr_ptr, r_rd_ptr;
    logic [c_CNT_NBITS-1:0]      r_count;
    logic [1:0]                  w_push_n;
    logic [1:0][c_ACT_NBITS-1:0] w_act;
    logic                        w_beat, w_pop;

    logic [REGADDR_NBITS-1:0] w_hdr_chan;
    logic                     w_hdr_mis, w_4dw_bad, w_is_mem;

    assign rxReady_out  = (r_count <= c_CNT_RDY);
    assign actValid_out = (r_count != '0);
    assign actData_out  = actValid_out ? r_mem[r_rd_ptr] : '0;
    assign errCount_out = r_err_cnt;
    assign w_beat       = rxValid_in && rxReady_out;
    assign w_pop        = actValid_out && actReady_in;
    assign w_err_sum    = {1'b0, r_err_cnt} + 17'(w_err_add);
    assign w_is_mem     = (r_type == c_TYPE_MEM_RW) && !r_fmt[2];

`ifdef TLP_RX_4DW_EN
    // 4DW headers carry the low address DW in the upper half of the beat.
    assign w_hdr_chan = r_fmt[0] ? rxData_in[34 +: REGADDR_NBITS] : rxData_in[2 +: REGADDR_NBITS];
    assign w_hdr_mis  = r_fmt[0] ? rxData_in[34] : rxData_in[2];
    assign w_4dw_bad  = 1'b0;
`else
    assign w_hdr_chan = rxData_in[2 +: REGADDR_NBITS];
    assign w_hdr_mis  = rxData_in[2];
    assign w_4dw_bad  = r_fmt[0];
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_cur_state    = r_state;
        w_fmt_nxt      = r_fmt;
        w_type_nxt     = r_type;
        w_len_nxt      = r_len;
        w_req_id_nxt   = r_req_id;
        w_tag_nxt      = r_tag;
        w_is_reg_nxt   = r_is_reg;
        w_chan_nxt     = r_chan;
        w_rem_nxt      = r_rem;
        w_skip_lo_nxt  = r_skip_lo;
        w_err_pend_nxt = r_err_pend;
        w_ch           = r_chan;
        w_rm           = r_rem;
        w_push_n       = 2'd0;
        w_act          = '0;
        w_err_add      = 2'd0;

        // A deferred short-packet error is only ever pending in IDLE/DROP, so it
        // never competes with data pushes for the two push slots.
        if (r_err_pend && (r_count != c_CNT_FULL)) begin
            w_act[0]       = mk_err(c_ERR_EOP);
            w_push_n       = 2'd1;
            w_err_add      = 2'd1;
            w_err_pend_nxt = 1'b0;
        end

        if (w_beat) begin
            if (rxSOP_in && (r_state != c_ST_IDLE)) begin
                if (r_is_reg) begin
                    w_act[w_push_n[0]] = mk_err(c_ERR_ABORT);
                    w_push_n           = w_push_n + 2'd1;
                    w_err_add          = w_err_add + 2'd1;
                end
                w_cur_state = c_ST_IDLE;
            end

            case (w_cur_state)
                c_ST_IDLE: begin
                    if (rxSOP_in) begin
                        w_fmt_nxt    = rxData_in[31:29];
                        w_type_nxt   = rxData_in[28:24];
                        w_len_nxt    = rxData_in[9:0];
                        w_req_id_nxt = rxData_in[63:48];
                        w_tag_nxt    = rxData_in[47:40];
                        w_is_reg_nxt = (rxBar_in == c_SOP_REG);
                        if (rxBar_in == c_SOP_REG) w_state_nxt = c_ST_HDR1;
                        else                       w_state_nxt = rxEOP_in ? c_ST_IDLE : c_ST_DROP;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end

                c_ST_HDR1: begin
                    w_state_nxt = rxEOP_in ? c_ST_IDLE : c_ST_DROP;
                    if (!w_is_mem || w_4dw_bad) begin
                        w_act[0] = mk_err(c_ERR_TYPE);
                        w_push_n = 2'd1;
                        w_err_add = 2'd1;
                    end else if (!r_fmt[1]) begin
                        if (r_len == c_LEN_ONE) begin
                            w_act[0]    = mk_act(c_TYP_READ, w_hdr_chan, {r_req_id, r_tag, 8'h00});
                            w_push_n    = 2'd1;
                            w_state_nxt = c_ST_IDLE;
                        end else begin
                            w_act[0]  = mk_err(c_ERR_RDLEN);
                            w_push_n  = 2'd1;
                            w_err_add = 2'd1;
                        end
                    end else if ((r_len == 10'd0) || (r_len > c_MAX_LEN)) begin
                        w_act[0]  = mk_err(c_ERR_LEN);
                        w_push_n  = 2'd1;
                        w_err_add = 2'd1;
                    end else begin
                        w_ch = w_hdr_chan;
                        w_rm = r_len;
                        // Misaligned 3DW write: first data DW shares the address beat.
                        if (!r_fmt[0] && w_hdr_mis) begin
                            w_act[0] = mk_act(c_TYP_WRITE, w_ch, rxData_in[63:32]);
                            w_push_n = 2'd1;
                            w_ch     = w_ch + c_CHAN_ONE;
                            w_rm     = w_rm - c_LEN_ONE;
                        end
                        w_chan_nxt    = w_ch;
                        w_rem_nxt     = w_rm;
                        w_skip_lo_nxt = w_hdr_mis && !(!r_fmt[0] && w_hdr_mis);
                        if ((w_rm == 10'd0) && rxEOP_in) begin
                            w_state_nxt = c_ST_IDLE;
                        end else if ((w_rm == 10'd0) || rxEOP_in) begin
                            w_act[w_push_n[0]] = mk_err(c_ERR_EOP);
                            w_push_n           = w_push_n + 2'd1;
                            w_err_add          = 2'd1;
                            w_state_nxt        = rxEOP_in ? c_ST_IDLE : c_ST_DROP;
                        end else begin
                            w_state_nxt = c_ST_DATA;
                        end
                    end
                end

                c_ST_DATA: begin
                    if (!r_skip_lo && (w_rm != 10'd0)) begin
                        w_act[0] = mk_act(c_TYP_WRITE, w_ch, rxData_in[31:0]);
                        w_push_n = 2'd1;
                        w_ch     = w_ch + c_CHAN_ONE;
                        w_rm     = w_rm - c_LEN_ONE;
                    end
                    if (w_rm != 10'd0) begin
                        w_act[w_push_n[0]] = mk_act(c_TYP_WRITE, w_ch, rxData_in[63:32]);
                        w_push_n           = w_push_n + 2'd1;
                        w_ch               = w_ch + c_CHAN_ONE;
                        w_rm               = w_rm - c_LEN_ONE;
                    end
                    w_chan_nxt    = w_ch;
                    w_rem_nxt     = w_rm;
                    w_skip_lo_nxt = 1'b0;
                    if ((w_rm == 10'd0) || rxEOP_in) begin
                        w_state_nxt    = rxEOP_in ? c_ST_IDLE : c_ST_DROP;
                        w_err_pend_nxt = !((w_rm == 10'd0) && rxEOP_in);
                    end
                end

                default: begin
                    if (rxEOP_in) w_state_nxt = c_ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge pcieClk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state    <= c_ST_IDLE;
            r_fmt      <= '0;
            r_type     <= '0;
            r_len      <= '0;
            r_req_id   <= '0;
            r_tag      <= '0;
            r_is_reg   <= 1'b0;
            r_chan     <= '0;
            r_rem      <= '0;
            r_skip_lo  <= 1'b0;
            r_err_pend <= 1'b0;
            r_err_cnt  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fmt      <= w_fmt_nxt;
            r_type     <= w_type_nxt;
            r_len      <= w_len_nxt;
            r_req_id   <= w_req_id_nxt;
            r_tag      <= w_tag_nxt;
            r_is_reg   <= w_is_reg_nxt;
            r_chan     <= w_chan_nxt;
            r_rem      <= w_rem_nxt;
            r_skip_lo  <= w_skip_lo_nxt;
            r_err_pend <= w_err_pend_nxt;
            r_err_cnt  <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
            r_wr_ptr   <= r_wr_ptr + c_PTR_NBITS'(w_push_n);
            r_rd_ptr   <= r_rd_ptr + c_PTR_NBITS'(w_pop);
            r_count    <= r_count + c_CNT_NBITS'(w_push_n) - c_CNT_NBITS'(w_pop);
        end
    end

    always_ff @(posedge pcieClk_in) begin
        if (w_push_n != 2'd0) r_mem[r_wr_ptr] <= w_act[0];
        if (w_push_n == 2'd2) r_mem[r_wr_ptr + c_PTR_ONE] <= w_act[1];
    end

endmodule
`default_nettype wire

// File: doc/tlp_rx_parser.md
Name: tlp_rx_parser

Overview:
- Parses inbound 64-bit Avalon-ST RX TLPs that hit the register BAR and converts them into RX->TX pipe actions: RegRead, RegWrite and ErrorCode.
- Successor to the single-DW register write path. Adds multi-DW burst writes, where each DW becomes one RegWrite with an auto-incrementing channel.
- Parametrised register address width, maximum burst length and output buffering.
- Sits between the PCIe hard-IP RX port and the tlp_xcvr TX/register logic.

Parameters:
- REGADDR_NBITS, 10, width of ExtChan (channel = low REGADDR_NBITS bits of the DW address).
- MAX_BURST_DW, 16, largest accepted write dwCount (1..1023).
- FIFO_DEPTH, 8, action buffer entries; power of two, ≥4.

Ports:
- pcieClk_in  in  1  core clock.
- reset_in  in  1  asynchronous, active-high reset.
- rxData_in  in  64  RX beat; DW0 in [31:0].
- rxValid_in  in  1  beat valid.
- rxReady_out  out  1  parser can accept a beat.
- rxSOP_in  in  1  start of packet.
- rxEOP_in  in  1  end of packet.
- rxBar_in  in  2  SopBar code, sampled with SOP.
- actData_out  out  34+REGADDR_NBITS  packed Action: typ, then chan, then 32-bit payload (MSB first).
- actValid_out  out  1  action available.
- actReady_in  in  1  consumer accepts action.
- errCount_out  out  16  saturating count of ErrorCode actions emitted.

Interface decision: one clock, pcieClk_in; reset_in is asynchronous and active-high.

Behaviour:
- Beat transfer: rxValid_in && rxReady_out. Action transfer: actValid_out && actReady_in.
- rxReady_out = (FIFO free entries ≥ 2), computed from the registered occupancy. Each accepted beat pushes at most 2 actions.
- Reset values: rxReady_out=1, actValid_out=0, actData_out=0, errCount_out=0, FIFO empty, state IDLE. Reset mid-packet discards the partial packet.
- State machine: IDLE, HDR1, DATA, DROP.
- IDLE: beats without SOP are ignored. On an SOP beat, latch fmt, type, dwCount, reqID[63:48], tag[47:40], bar.
  - bar≠SOP_REG: go to DROP, with no action and no error.
  - Otherwise go to HDR1.
- HDR1: latch the DW address.
  - 3DW header: address = bits[31:2].
  - 4DW header: address = bits[63:34]; the upper 32 address bits are ignored.
  - Read (fmt=NODATA, type=MEM_RW_REQ):
    - dwCount=1: push RegRead(chan, reqID, tag), then IDLE.
    - Otherwise: push ErrorCode 2, then DROP (or IDLE if EOP).
  - Write (fmt=WITHDATA, type=MEM_RW_REQ):
    - dwCount=0 or dwCount>MAX_BURST_DW: push ErrorCode 1, then DROP.
    - 3DW header with a QW-misaligned address (byte-address bit 2 = 1): data DW0 is bits[63:32] of this beat; push it.
    - Any other write goes to DATA.
  - Any other type/fmt: ErrorCode 3, then DROP.
- DATA: consume DWs in order.
  - First data beat after a 4DW header, or after a QW-aligned 3DW header: aligned address means the lower DW is first; misaligned means the lower DW is padding.
  - Up to 2 RegWrites per beat; lower DW is pushed first.
  - chan increments by 1 per DW, modulo 2^REGADDR_NBITS.
  - Return to IDLE when the remaining count reaches 0. That beat must carry EOP.
- Error conditions:
  - EOP before the count is exhausted: ErrorCode 4, then IDLE.
  - Count exhausted without EOP: ErrorCode 4, then DROP.
  - SOP seen in HDR1/DATA/DROP: ErrorCode 5 for the aborted packet (only if it was a REG packet); the new SOP beat is processed as in IDLE in the same cycle.
- DROP: discard beats until EOP, then IDLE.
- Ordering: at most 2 pushes per cycle; an error push counts as one. FIFO is first-word-fall-through.
  - actData_out is valid whenever actValid_out=1.
  - Pop and push in the same cycle is allowed.
- errCount_out increments when an ErrorCode is pushed and saturates at 0xFFFF.
- Payload layouts:
  - RegRead payload = {reqID, tag, 8'h00}.
  - RegWrite payload = data.
  - ErrorCode: chan=0, payload=code.

Optional Feature:
- Macro: TLP_RX_4DW_EN.
- Defined: 4DW headers (fmt H4DW_*) are accepted as described.
- Undefined: any REG-BAR packet with a 4DW header produces ErrorCode 3 and DROP, and the 4DW address path is not synthesised.

Test Plan:
- Aligned burst:
  - Stimulus: 3DW MWr, dwCount=3, byte addr 0x1008. Beats: {pad, addr}, {d1=0xB, d0=0xA}, {-, d2=0xC}+EOP.
  - Response: RegWrite (2,0xA), (3,0xB), (4,0xC) in order; errCount_out=0.
- Misaligned burst with wrap:
  - Stimulus: 3DW MWr, dwCount=2, byte addr 0xFFC, data 0x11 in beat1[63:32], 0x22 in beat2[31:0].
  - Response: RegWrite (0x3FF,0x11), then (0x000,0x22).
- Register read:
  - Stimulus: 3DW MRd, reqID=0x0100, tag=0x2A, byte addr 0x14.
  - Response: one RegRead, chan=5, payload 0x01002A00.
- Error handling:
  - Stimulus A: MWr dwCount=17. Response: ErrorCode 1, packet dropped.
  - Stimulus B: then MRd dwCount=2. Response: ErrorCode 2; errCount_out=2.
  - Stimulus C: then an SOP mid-burst. Response: ErrorCode 5, and the new packet is decoded normally.
- Backpressure:
  - Stimulus: 16-DW aligned burst with actReady_in held low for 10 cycles.
  - Response: rxReady_out deasserts when free<2; all 16 RegWrites arrive in order, with none lost or duplicated.
- Reset and non-REG BAR:
  - Stimulus A: assert reset_in mid-burst. Response: outputs return to reset values immediately; the next packet decodes correctly.
  - Stimulus B: a SOP_C2F packet. Response: no action emitted.
